frame_store_dbuf: RTL

//  Double-buffered 1-bit-per-pixel frame store feeding the VGA output stage.

---
 rtl/frame_store_pkg.sv | 30 +++
 rtl/frame_store_ram.sv | 26 ++
 rtl/frame_store_dbuf.sv | 123 ++++++++++++
 3 files changed

// File: rtl/frame_store_pkg.sv
// Shared types and sizing for the double-buffered 1bpp frame store.
// Optional build macro used by the top: FRAME_STORE_AUTOCLEAR_EN.
package frame_store_pkg;

  typedef enum logic [1:0] {
    FS_IDLE      = 2'd0,
    FS_CLEAR     = 2'd1,
    FS_SWAP_WAIT = 2'd2
  } fs_state_t;

  localparam int DEF_WIDTH  = 640;
  localparam int DEF_HEIGHT = 480;
  localparam int DEF_NPIX   = DEF_WIDTH * DEF_HEIGHT;
  localparam int DEF_PIX_AW = $clog2(DEF_NPIX);

  typedef logic [$clog2(DEF_WIDTH)-1:0]  x_coord_t;
  typedef logic [$clog2(DEF_HEIGHT)-1:0] y_coord_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Index width of one buffer; the buffer select bit sits just above it.
  function automatic int pix_aw(input int w, input int h);
    return $clog2(w * h);
  endfunction

endpackage

// File: rtl/frame_store_ram.sv
// Simple dual-port 1-bit RAM: one write port, one registered read port.
// Array is not reset; only the read register clears on reset.
module frame_store_ram #(
  parameter int AW = 6
) (
  input  logic          clk50,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic          wdat,
  input  logic [AW-1:0] raddr,
  output logic          rdat
);

  logic mem [2**AW];

  always_ff @(posedge clk50) begin
    if (we) mem[waddr] <= wdat;
  end

  always_ff @(posedge clk50) begin
    if (reset) rdat <= 1'b0;
    else       rdat <= mem[raddr];
  end

endmodule

// File: rtl/frame_store_dbuf.sv
// Double-buffered 1bpp frame store: front buffer feeds the display, back buffer takes draws.
// Swaps only on a vblank rising edge; FRAME_STORE_AUTOCLEAR_EN clears the new back buffer after each swap.
module frame_store_dbuf
  import frame_store_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int XW     = $clog2(WIDTH),
  parameter int YW     = $clog2(HEIGHT)
) (
  input  logic          clk50,
  input  logic          reset,
  input  logic [XW-1:0] rd_x,
  input  logic [YW-1:0] rd_y,
  output logic [7:0]    r,
  output logic [7:0]    g,
  output logic [7:0]    b,
  input  logic          vblank,
  input  logic [23:0]   fg_color,
  input  logic [23:0]   bg_color,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [XW-1:0] wr_x,
  input  logic [YW-1:0] wr_y,
  input  logic          wr_pixel,
  input  logic          clear_req,
  input  logic          swap_req,
  output logic          swap_ack,
  output logic          busy
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int PAW  = pix_aw(WIDTH, HEIGHT);

  fs_state_t      state, state_nxt;
  logic           front_sel, vblank_q, vblank_rise;
  logic [PAW-1:0] clr_cnt, wr_idx, rd_idx;
  logic           clr_last, clear_en;
  logic           wr_in_range, rd_oor, oor_q, pix_q;
  logic           ram_we, ram_wd;
  logic [PAW:0]   ram_wa, ram_ra;
  rgb_t           px_col;

  assign vblank_rise = vblank & ~vblank_q;
  assign clr_last    = (clr_cnt == PAW'(NPIX - 1));

  // Out-of-range coordinates alias onto real pixels here; they are masked below.
  assign wr_in_range = (int'(wr_x) < WIDTH) && (int'(wr_y) < HEIGHT);
  assign rd_oor      = (int'(rd_x) >= WIDTH) || (int'(rd_y) >= HEIGHT);
  assign wr_idx      = PAW'(int'(wr_y) * WIDTH + int'(wr_x));
  assign rd_idx      = PAW'(int'(rd_y) * WIDTH + int'(rd_x));

  always_ff @(posedge clk50) begin
    if (reset) state <= FS_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FS_IDLE: begin
        if (clear_req)     state_nxt = FS_CLEAR;
        else if (swap_req) state_nxt = FS_SWAP_WAIT;
      end
      FS_CLEAR: begin
        if (clr_last) state_nxt = FS_IDLE;
      end
      FS_SWAP_WAIT: begin
        if (vblank_rise) begin
`ifdef FRAME_STORE_AUTOCLEAR_EN
          state_nxt = FS_CLEAR;
`else
          state_nxt = FS_IDLE;
`endif
        end
      end
      default: state_nxt = FS_IDLE;
    endcase
  end

  always_comb begin
    wr_ready = (state == FS_IDLE);
    busy     = (state != FS_IDLE);
    clear_en = (state == FS_CLEAR);
    swap_ack = (state == FS_SWAP_WAIT) && vblank_rise;
  end

  always_ff @(posedge clk50) begin
    if (reset) begin
      clr_cnt   <= '0;
      front_sel <= 1'b0;
      vblank_q  <= 1'b0;
      oor_q     <= 1'b0;
    end else begin
      if (clear_en) clr_cnt <= clr_last ? '0 : clr_cnt + 1'b1;
      if (swap_ack) front_sel <= ~front_sel;
      vblank_q <= vblank;
      oor_q    <= rd_oor;
    end
  end

  // Drawing and clearing always target the back buffer; the display always reads the front.
  assign ram_we = ~reset & ((wr_valid & wr_ready & wr_in_range) | clear_en);
  assign ram_wd = ~clear_en & wr_pixel;
  assign ram_wa = {~front_sel, (clear_en ? clr_cnt : wr_idx)};
  assign ram_ra = {front_sel, rd_idx};

  frame_store_ram #(.AW(PAW + 1)) u_ram (
    .clk50 (clk50),
    .reset (reset),
    .we    (ram_we),
    .waddr (ram_wa),
    .wdat  (ram_wd),
    .raddr (ram_ra),
    .rdat  (pix_q)
  );

  assign px_col = (pix_q & ~oor_q) ? rgb_t'(fg_color) : rgb_t'(bg_color);
  assign r = px_col.r;
  assign g = px_col.g;
  assign b = px_col.b;

endmodule
